// File: rtl/he_mem_rd_arbiter.sv
// Round-robin arbiter sharing one memory AXI read channel among NUM_REQ requesters.
// Winner indices are queued in a route FIFO so in-order read bursts return to their owner.
module he_mem_rd_arbiter #(
  parameter int NUM_REQ          = 2,
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 512,
  parameter int ROUTE_DEPTH_LOG2 = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_arvalid,
  output logic [NUM_REQ-1:0]            req_arready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr,
  input  logic [NUM_REQ*8-1:0]          req_arlen,
  output logic [NUM_REQ-1:0]            req_rvalid,
  input  logic [NUM_REQ-1:0]            req_rready,
  output logic [DATA_WIDTH-1:0]         req_rdata,
  output logic                          req_rlast,
  output logic                          mem_arvalid,
  input  logic                          mem_arready,
  output logic [ADDR_WIDTH-1:0]         mem_araddr,
  output logic [7:0]                    mem_arlen,
  input  logic                          mem_rvalid,
  output logic                          mem_rready,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  input  logic                          mem_rlast,
  output logic [ROUTE_DEPTH_LOG2:0]     outstanding
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int DEPTH = 1 << ROUTE_DEPTH_LOG2;
  localparam logic [ROUTE_DEPTH_LOG2:0] DEPTH_CNT = (ROUTE_DEPTH_LOG2+1)'(DEPTH);

  logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]            win_idx, cand;
  logic                        win_found;
  logic                        accept;

  logic                        arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0]       araddr_q, araddr_d;
  logic [7:0]                  arlen_q, arlen_d;

  logic [IDX_W-1:0]            route_mem [DEPTH];
  logic [ROUTE_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ROUTE_DEPTH_LOG2:0]   count_q, count_d;
  logic                        fifo_full, fifo_empty;
  logic [IDX_W-1:0]            head_idx;
  logic                        push, pop;

  // Scan from the farthest candidate back to rr_ptr so the nearest valid one wins.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    win_idx   = rr_ptr_q;
    win_found = 1'b0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_arvalid[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  assign fifo_full  = (count_q == DEPTH_CNT);
  assign fifo_empty = (count_q == '0);
  assign accept     = !rst && win_found && (!arvalid_q || mem_arready) && !fifo_full;

  always_comb begin
    req_arready = '0;
    if (accept) req_arready[win_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    if (accept) begin
      rr_ptr_d  = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      arvalid_d = 1'b1;
      araddr_d  = req_araddr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
      arlen_d   = req_arlen[win_idx*8 +: 8];
    end else if (mem_arready) begin
      arvalid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
    end
  end

  assign mem_arvalid = arvalid_q;
  assign mem_araddr  = araddr_q;
  assign mem_arlen   = arlen_q;

  assign head_idx = route_mem[rd_ptr_q];
  assign push     = accept;
  assign pop      = mem_rvalid && mem_rready && mem_rlast;

  always_comb begin
    req_rvalid = '0;
    mem_rready = 1'b0;
    if (!fifo_empty) begin
      req_rvalid[head_idx] = mem_rvalid;
      mem_rready           = req_rready[head_idx];
    end
  end

  assign req_rdata = mem_rdata;
  assign req_rlast = mem_rlast;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: route storage has no reset; entries are only read once the pointers say they are valid.
  always_ff @(posedge clk) begin
    if (push) route_mem[wr_ptr_q] <= win_idx;
  end

  assign outstanding = count_q;

endmodule

// File: tb/tb_he_mem_rd_arbiter.sv
// Directed bench for he_mem_rd_arbiter: 4 requesters, 4-deep route FIFO.
// Inputs change just after the falling edge; outputs are compared 1 ns later.
module tb_he_mem_rd_arbiter;

  localparam int NR  = 4;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int RDL = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_arvalid, req_arready, req_rvalid, req_rready;
  logic [NR*AW-1:0]  req_araddr;
  logic [NR*8-1:0]   req_arlen;
  logic [DW-1:0]     req_rdata, mem_rdata;
  logic              req_rlast, mem_rlast;
  logic              mem_arvalid, mem_arready, mem_rvalid, mem_rready;
  logic [AW-1:0]     mem_araddr;
  logic [7:0]        mem_arlen;
  logic [RDL:0]      outstanding;

  logic [AW-1:0]     addr_a [NR];
  logic [7:0]        len_a  [NR];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_araddr = '0;
    req_arlen  = '0;
    for (int i = 0; i < NR; i++) begin
      req_araddr[i*AW +: AW] = addr_a[i];
      req_arlen[i*8 +: 8]    = len_a[i];
    end
  end

  he_mem_rd_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUTE_DEPTH_LOG2(RDL)
  ) dut (
    .clk(clk), .rst(rst),
    .req_arvalid(req_arvalid), .req_arready(req_arready),
    .req_araddr(req_araddr), .req_arlen(req_arlen),
    .req_rvalid(req_rvalid), .req_rready(req_rready),
    .req_rdata(req_rdata), .req_rlast(req_rlast),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
    .mem_araddr(mem_araddr), .mem_arlen(mem_arlen),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
    .mem_rdata(mem_rdata), .mem_rlast(mem_rlast),
    .outstanding(outstanding)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int route [4];
    int burst, beat, h;
    int delivered [NR];
    logic tog;

    rst = 1'b1;
    req_arvalid = '0; req_rready = '0;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rlast = 1'b0;
    for (int i = 0; i < NR; i++) begin
      addr_a[i] = AW'(256 * (i + 1));
      len_a[i]  = 8'(i);
      delivered[i] = 0;
    end
    repeat (2) nxt();

    // Reset held with live stimulus: every output must stay quiet.
    req_arvalid = '1; mem_rvalid = 1'b1; req_rready = '1;
    #1;
    check("rst_arready", req_arready, 0);
    check("rst_rvalid",  req_rvalid, 0);
    check("rst_mrready", mem_rready, 0);
    check("rst_arvalid", mem_arvalid, 0);
    check("rst_araddr",  mem_araddr, 0);
    check("rst_arlen",   mem_arlen, 0);
    check("rst_outst",   outstanding, 0);

    // Round-robin with all requesters valid; single-beat responses drain the FIFO.
    rst = 1'b0; mem_arready = 1'b1; mem_rlast = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_grant", req_arready, 4'b0001 << (k % 4));
      if (k > 0) begin
        check("rr_araddr", mem_araddr, addr_a[(k - 1) % 4]);
        check("rr_arlen",  mem_arlen, len_a[(k - 1) % 4]);
        check("rr_outst",  outstanding, 1);
      end
      nxt();
    end
    req_arvalid = '0;
    #1;
    check("rr_tail_rvalid", req_rvalid, 4'b0001);
    check("rr_tail_mrready", mem_rready, 1);
    check("rr_tail_outst", outstanding, 1);
    nxt();
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    #1;
    check("rr_drained", outstanding, 0);
    check("rr_ar_clear", mem_arvalid, 0);
    nxt();

    // Single 4-beat burst from requester 2.
    addr_a[2] = 32'h1000; len_a[2] = 8'd3; req_arvalid = 4'b0100;
    #1;
    check("b2_arready", req_arready, 4'b0100);
    nxt();
    req_arvalid = '0;
    #1;
    check("b2_arvalid", mem_arvalid, 1);
    check("b2_araddr",  mem_araddr, 32'h1000);
    check("b2_arlen",   mem_arlen, 3);
    check("b2_outst",   outstanding, 1);
    nxt();
    for (int b = 0; b < 4; b++) begin
      mem_rvalid = 1'b1; mem_rdata = 64'hA000 + 64'(b); mem_rlast = (b == 3); req_rready = '1;
      #1;
      check("b2_rvalid",  req_rvalid, 4'b0100);
      check("b2_rdata",   req_rdata, 64'hA000 + 64'(b));
      check("b2_rlast",   req_rlast, (b == 3));
      check("b2_mrready", mem_rready, 1);
      check("b2_outst_beat", outstanding, 1);
      nxt();
    end
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    #1;
    check("b2_outst_done", outstanding, 0);
    check("b2_rvalid_idle", req_rvalid, 0);
    nxt();

    // Memory AR stalled for 5 cycles with requesters 0 and 1 pending (pointer at 3).
    mem_arready = 1'b0;
    addr_a[0] = 32'h2000; len_a[0] = 8'h0F;
    addr_a[1] = 32'h3000; len_a[1] = 8'h07;
    req_arvalid = 4'b0011;
    #1;
    check("stall_first", req_arready, 4'b0001);
    nxt();
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_arready", req_arready, 0);
      check("stall_arvalid", mem_arvalid, 1);
      check("stall_araddr",  mem_araddr, 32'h2000);
      check("stall_arlen",   mem_arlen, 8'h0F);
      nxt();
    end
    mem_arready = 1'b1;
    #1;
    check("stall_release_grant", req_arready, 4'b0010);
    check("stall_release_addr",  mem_araddr, 32'h2000);
    nxt();
    req_arvalid = '0;
    #1;
    check("stall_next_arvalid", mem_arvalid, 1);
    check("stall_next_araddr",  mem_araddr, 32'h3000);
    check("stall_next_arlen",   mem_arlen, 8'h07);
    nxt();
    #1;
    check("stall_ar_clear", mem_arvalid, 0);
    check("stall_outst", outstanding, 2);
    nxt();
    mem_rvalid = 1'b1; mem_rlast = 1'b1; req_rready = '1;
    #1;
    check("stall_rt0", req_rvalid, 4'b0001);
    nxt();
    #1;
    check("stall_rt1", req_rvalid, 4'b0010);
    nxt();
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    #1;
    check("stall_drained", outstanding, 0);
    nxt();

    // Route FIFO full: 4 bursts from requester 0 with no responses.
    addr_a[0] = 32'h4000; req_arvalid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("full_fill_grant", req_arready, 4'b0001);
      nxt();
    end
    #1;
    check("full_outst", outstanding, 4);
    check("full_blocked", req_arready, 0);
    nxt();
    mem_rvalid = 1'b1; mem_rlast = 1'b1; req_rready = '1;
    #1;
    check("full_pop_cycle_blocked", req_arready, 0);
    check("full_pop_rvalid", req_rvalid, 4'b0001);
    nxt();
    mem_rvalid = 1'b0;
    #1;
    check("full_after_pop_outst", outstanding, 3);
    check("full_after_pop_grant", req_arready, 4'b0001);
    nxt();
    req_arvalid = '0;
    #1;
    check("full_refilled", outstanding, 4);
    nxt();
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = 1'b1;
      #1;
      check("full_drain_rvalid", req_rvalid, 4'b0001);
      nxt();
    end
    #1;
    check("empty_outst", outstanding, 0);
    check("empty_rvalid", req_rvalid, 0);
    check("empty_mrready", mem_rready, 0);
    nxt();
    mem_rvalid = 1'b0; mem_rlast = 1'b0;

    // Interleaved bursts from requesters 1 and 3 (pointer at 1), 2 beats each.
    route = '{1, 3, 1, 3};
    len_a[1] = 8'd1; len_a[3] = 8'd1;
    req_arvalid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("il_grant", req_arready, 4'b0001 << route[k]);
      nxt();
    end
    req_arvalid = '0;
    #1;
    check("il_outst", outstanding, 4);
    nxt();
    burst = 0; beat = 0;
    for (int c = 0; c < 40 && burst < 4; c++) begin
      h   = route[burst];
      tog = (c % 3 != 1);
      req_rready = tog ? (4'b0001 << h) : ~(4'b0001 << h);
      mem_rvalid = 1'b1;
      mem_rdata  = 64'(burst * 16 + beat);
      mem_rlast  = (beat == 1);
      #1;
      check("il_rvalid",  req_rvalid, 4'b0001 << h);
      check("il_mrready", mem_rready, tog);
      check("il_rdata",   req_rdata, 64'(burst * 16 + beat));
      for (int r = 0; r < NR; r++)
        if (req_rvalid[r] && req_rready[r]) delivered[r]++;
      if (tog) begin
        beat++;
        if (beat == 2) begin
          beat = 0;
          burst++;
        end
      end
      nxt();
    end
    mem_rvalid = 1'b0; mem_rlast = 1'b0; req_rready = '0;
    #1;
    check("il_all_bursts", burst, 4);
    check("il_req1_beats", delivered[1], 4);
    check("il_req3_beats", delivered[3], 4);
    check("il_req0_beats", delivered[0], 0);
    check("il_drained", outstanding, 0);
    nxt();

    // Asynchronous reset mid-operation with 3 bursts outstanding and AR pending.
    req_arvalid = 4'b0001; mem_arready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("mid_grant", req_arready, 4'b0001);
      nxt();
    end
    req_arvalid = '0; mem_arready = 1'b0;
    #1;
    check("mid_outst", outstanding, 3);
    check("mid_arvalid", mem_arvalid, 1);
    #1;
    rst = 1'b1; req_arvalid = '1; mem_rvalid = 1'b1; req_rready = '1;
    #1;
    check("arst_arvalid", mem_arvalid, 0);
    check("arst_araddr",  mem_araddr, 0);
    check("arst_arlen",   mem_arlen, 0);
    check("arst_outst",   outstanding, 0);
    check("arst_arready", req_arready, 0);
    check("arst_rvalid",  req_rvalid, 0);
    check("arst_mrready", mem_rready, 0);
    nxt();
    rst = 1'b0; mem_arready = 1'b1; mem_rvalid = 1'b0; req_arvalid = 4'b0101;
    #1;
    check("post_rst_grant", req_arready, 4'b0001);
    nxt();
    req_arvalid = '0;
    #1;
    check("post_rst_arvalid", mem_arvalid, 1);
    check("post_rst_araddr",  mem_araddr, addr_a[0]);
    check("post_rst_outst",   outstanding, 1);
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/he_mem_rd_arbiter.md
HE_MEM_RD_ARBITER -- requirements
Module: he_mem_rd_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2: number of read requesters, any integer from 2 to 8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32: byte address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 512: read data width.
REQ-004 The block SHALL have parameter ROUTE_DEPTH_LOG2, default 6: log2 of the maximum number of outstanding bursts.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-006 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  sole clock.
- rst  in  1  asynchronous active-high reset.
- req_arvalid  in  NUM_REQ  per-requester read address valid.
- req_arready  out  NUM_REQ  per-requester read address accept.
- req_araddr  in  NUM_REQ*ADDR_WIDTH  requester i at slice i.
- req_arlen  in  NUM_REQ*8  AXI burst length minus 1.
- req_rvalid  out  NUM_REQ  routed read data valid.
- req_rready  in  NUM_REQ  per-requester read data ready.
- req_rdata  out  DATA_WIDTH  read data, broadcast to all requesters.
- req_rlast  out  1  last beat of burst, broadcast.
- mem_arvalid, mem_arready, mem_araddr, mem_arlen  out/in/out/out  1/1/ADDR_WIDTH/8  shared memory read address channel.
- mem_rvalid, mem_rready, mem_rdata, mem_rlast  in/out/in/in  1/1/DATA_WIDTH/1  shared memory read data channel; responses arrive in order.
- outstanding  out  ROUTE_DEPTH_LOG2+1  bursts issued and not yet completed.

Function
REQ-007 Arbitration SHALL be round-robin: the winner is the first asserted req_arvalid at or after pointer rr_ptr, searching upward with wrap modulo NUM_REQ.
REQ-008 An accept SHALL occur when req_arvalid[w] is asserted, mem_arvalid is low or mem_arready is high, and the route FIFO is not full.
REQ-009 req_arready[i] SHALL be high only for the winner w and only when the REQ-008 conditions hold; at most one bit SHALL be high per cycle.
REQ-010 On an accept, rr_ptr SHALL become (w+1) mod NUM_REQ; otherwise rr_ptr SHALL hold.
REQ-011 The mem AR output SHALL be a register stage: on an accept, mem_arvalid, mem_araddr and mem_arlen SHALL be loaded on the next edge, giving 1-cycle latency from req handshake to mem_arvalid.
REQ-012 mem_arvalid SHALL clear after a mem_arready handshake with no new accept.
REQ-013 mem_araddr and mem_arlen SHALL be stable while mem_arvalid is high and mem_arready is low.
REQ-014 Back-to-back accepts SHALL sustain one burst per cycle while mem_arready stays high.
REQ-015 The route FIFO SHALL hold 2**ROUTE_DEPTH_LOG2 winner indices, pushed on every accept and popped on mem_rvalid & mem_rready & mem_rlast.
REQ-016 When the route FIFO is full, the block SHALL accept no request; a pop in the same cycle SHALL NOT unblock the accept until the next cycle.
REQ-017 With head index h and the FIFO non-empty, req_rvalid[h] SHALL equal mem_rvalid, all other req_rvalid bits SHALL be 0, and mem_rready SHALL equal req_rready[h].
REQ-018 With the FIFO empty, req_rvalid SHALL be 0 and mem_rready SHALL be 0, so an unexpected beat is stalled and never dropped.
REQ-019 req_rdata and req_rlast SHALL be combinational copies of mem_rdata and mem_rlast, with zero latency on the R path.
REQ-020 outstanding SHALL increment on a push, decrement on a pop, and hold on a simultaneous push and pop; its range SHALL be 0..2**ROUTE_DEPTH_LOG2.
REQ-021 A non-last beat SHALL NOT pop the FIFO, so the burst stays routed to the same requester.

Reset
REQ-022 When rst is asserted, the block SHALL asynchronously set mem_arvalid=0, rr_ptr=0, route FIFO empty and outstanding=0.
REQ-023 While rst is asserted, req_arready, req_rvalid and mem_rready SHALL be 0.
REQ-024 The block SHALL discard in-flight bursts when reset is asserted mid-operation; after release it SHALL accept requests on the first clock edge.
REQ-025 mem_araddr and mem_arlen SHALL reset to 0.

Verification
REQ-026 The bench SHALL drive all 4 requesters (NUM_REQ=4) valid continuously with mem_arready=1, and SHALL check a grant order of 0,1,2,3,0 on consecutive cycles.
REQ-027 The bench SHALL present req 2 only, with addr 0x1000 and len 3, and SHALL check mem_arvalid the next cycle with addr 0x1000 and len 3; it SHALL then return 4 beats and check req_rvalid[2] on each beat and outstanding going 1 to 0 after rlast.
REQ-028 The bench SHALL hold mem_arready=0 for 5 cycles with requests pending, and SHALL check that mem_araddr is stable, req_arready is all 0 after the first accept, and the burst is issued when ready returns.
REQ-029 The bench SHALL use ROUTE_DEPTH_LOG2=2 and issue 4 bursts with no responses, and SHALL check outstanding=4 and req_arready=0; it SHALL then complete one burst and check an accept on the following cycle.
REQ-030 The bench SHALL interleave bursts from req 1 and req 3 while toggling req_rready of the head requester, and SHALL check that no beat is lost or misrouted and that mem_rready follows the head requester's req_rready.
REQ-031 The bench SHALL assert rst with outstanding=3 and mem_arvalid=1, and SHALL check all outputs at their REQ-022/REQ-025 values immediately, without waiting for a clock edge.
